// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package ifetch_pkg;

    localparam int          INST_W           = 32;
    localparam int          PC_W             = 32;
    localparam int          FQ_ENTRY_W       = PC_W + INST_W;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Registered circular prefetch queue with synchronous flush; head read is
// forced to zero when empty so downstream never sees stale entries.
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = FQ_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            if (push_ok) wr_q <= wr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: the empty gate on rdata_o hides stale words.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, push/pop/redirect control and the
// prefetch queue that decouples a combinational imem from decode.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    logic [31:0] pc_q, pc_d;
    logic        push, pop, full, empty;
    fq_entry_t   wr_entry, head;

    assign pop  = inst_valid && inst_ready;
    assign push = !redirect_valid && (!full || pop);

    assign wr_entry   = '{pc: pc_q, inst: imem_data};
    assign imem_addr  = pc_q;
    assign inst_valid = !empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc & ~32'h3;
        else if (push)      pc_d = pc_q + PC_INC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC & ~32'h3;
        else        pc_q <= pc_d;
    end

    // Redirect drives flush, which outranks any concurrent push/pop inside the queue.
    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (FQ_ENTRY_W)
    ) u_fq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus a long random run,
// all compared against a queue-based reference model of fetch behaviour.
module tb_ifetch;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_data, inst, inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] w_addr, w_data, w_inst, w_pc;
    logic        w_valid;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] mq[$];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h1000_0000 + {24'h0, a[9:2]};
    endfunction

    assign imem_data = memword(imem_addr);
    assign w_data    = memword(w_addr);

    ifetch #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_data(w_data),
        .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_pc), .inst_ready(1'b1),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = 32'h0;
    endtask

    task automatic check_model();
        chk("valid", {31'h0, inst_valid}, {31'h0, mq.size() != 0});
        chk("imem_addr", imem_addr, mpc);
        if (mq.size() != 0) begin
            chk("inst_pc", inst_pc, mq[0]);
            chk("inst", inst, memword(mq[0]));
        end
    endtask

    // Apply inputs for one edge, advance the model by the fetch rules, then check.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rp);
        bit pop, push;
        inst_ready     = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        pop  = (mq.size() != 0) && r;
        push = !rv && ((mq.size() < QD) || pop);
        if (rv) begin
            mq.delete();
            mpc = rp & ~32'h3;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        rst_n = 1'b1;
        model_reset();

        // Streaming with ready=1; the wrap instance runs alongside
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk("stream_pc", inst_pc, 32'(4 * i));
            chk("stream_inst", inst, 32'h1000_0000 + 32'(i));
            chk("wrap_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * i));
        end

        // Back-pressure fills the queue, then drains without gaps
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("full_addr", imem_addr, 32'h10);
        chk("full_head", inst_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", {31'h0, inst_valid}, 32'h1);
            chk("drain_pc", inst_pc, 32'(4 * i));
            cycle(1'b1, 1'b0, 32'h0);
        end

        // Redirect while full and ready
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0043);
        chk("redir_valid", {31'h0, inst_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h40);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_first", inst_pc, 32'h40);

        // Back-to-back redirects
        cycle(1'b1, 1'b1, 32'h0000_0100);
        cycle(1'b1, 1'b1, 32'h0000_0207);
        chk("b2b_addr", imem_addr, 32'h204);

        // Half-cycle reset pulse with 3 entries queued
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("pre_pulse_addr", imem_addr, 32'hC);
        #2 rst_n = 1'b0;
        #1;
        chk("pulse_valid", {31'h0, inst_valid}, 32'h0);
        chk("pulse_addr", imem_addr, 32'h0);
        chk("pulse_inst", inst, 32'h0);
        chk("pulse_inst_pc", inst_pc, 32'h0);
        #1 rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, 32'h0);
        chk("restart_pc", inst_pc, 32'h0);

        // Random ready and redirects
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning prefetch queue entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory (combinational-read memory, word index addr[9:2]).
REQ-006 SHALL have port imem_data  input  32  instruction word returned for imem_addr in the same cycle.
REQ-007 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-008 SHALL have port inst  output  32  queue-head instruction word.
REQ-009 SHALL have port inst_pc  output  32  byte address of queue-head instruction.
REQ-010 SHALL have port inst_ready  input  1  decode accepts head this cycle.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-012 SHALL have port redirect_pc  input  32  redirect target address.

Function
REQ-013 SHALL keep a fetch PC register; imem_addr SHALL equal the fetch PC every cycle, bits [1:0] always 0.
REQ-014 SHALL define push = !redirect_valid && (!full || pop) and pop = inst_valid && inst_ready.
REQ-015 On push, SHALL enqueue {fetch PC, imem_data} and advance the fetch PC by 4 at the clock edge.
REQ-016 Without push, the fetch PC SHALL hold its value.
REQ-017 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-018 The queue SHALL be registered: an entry pushed at edge N SHALL be visible on inst/inst_pc no earlier than the cycle after edge N (1-cycle fetch-to-valid latency).
REQ-019 inst, inst_pc, inst_valid SHALL come directly from the queue head; inst_valid=0 when the queue is empty.
REQ-020 While inst_valid=0, inst_ready SHALL be ignored (no pop, no underflow).
REQ-021 When the queue is full, push and pop in the same cycle SHALL both occur, so occupancy stays QDEPTH.
REQ-022 When the queue is full and there is no pop, there SHALL be no push and the PC SHALL hold; the full queue contents SHALL stay unchanged.
REQ-023 Redirect SHALL have priority over push and pop: at the edge it SHALL empty the queue, drop any concurrent pop/push, and load the fetch PC with {redirect_pc[31:2],2'b00}.
REQ-024 In the cycle after a redirect, inst_valid SHALL be 0 and imem_addr SHALL equal the new target.
REQ-025 Back-to-back redirects SHALL each take effect; the last one determines the fetch PC.
REQ-026 Queue entries SHALL be delivered strictly in fetch order with contiguous PCs between redirects.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately, with no clock edge, set the fetch PC to RESET_PC[31:2],2'b00, empty the queue, and drive inst_valid=0.
REQ-028 During reset, inst and inst_pc SHALL read 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries and any pending redirect.
REQ-030 The first push SHALL occur at the first posedge clk after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold the instruction width (32), the PC increment (4), and the default RESET_PC constant.
REQ-032 The queue SHALL be a sub-module named fetch_queue with push, pop, flush, full, and empty, parameterised by depth and entry width (64 bits: PC plus instruction).
REQ-033 ifetch SHALL contain only the PC register, the push/pop/redirect control, and the fetch_queue instance.

Verification
REQ-034 Reset release with RESET_PC=0, memory word k = 32'h1000_0000+k, inst_ready=1 -> the first valid cycle shows inst_pc=0 and inst=32'h1000_0000, then one instruction per cycle with PCs 4, 8, 12.
REQ-035 inst_ready=0 for 10 cycles after reset -> the queue fills to 4 entries, imem_addr holds 32'h10, the head stays at PC 0; on releasing inst_ready, PCs 0, 4, 8, 12, 16 are delivered without gap.
REQ-036 Redirect to 32'h0000_0043 while the queue is full and inst_ready=1 -> no pop that cycle, inst_valid=0 the next cycle, imem_addr=32'h40, then the first delivered inst_pc=32'h40.
REQ-037 RESET_PC=32'hFFFF_FFF8, inst_ready=1 -> delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-038 rst_n pulsed low for half a cycle while the queue holds 3 entries -> inst_valid falls immediately with no clock edge, imem_addr=RESET_PC, and fetch restarts from RESET_PC.
REQ-039 Random inst_ready and redirects over 10k cycles, checked by a reference model -> in-order delivery, no duplicates, no loss between redirects, no pop while empty.
